// File: rtl/mem_d_copy_engine_pkg.sv
// Shared types and constants for the mem_d word-copy engine.
package mem_d_pkg;

  localparam int unsigned TAG_W = 11;

  localparam logic [3:0] WR_ALL  = 4'hF;
  localparam logic [3:0] WR_NONE = 4'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT
  } state_e;

endpackage

// File: rtl/mem_d_copy_engine_if.sv
// Data-side memory request bus (mem_d_*): master drives requests, slave returns responses.
interface mem_d_copy_engine_if;
  import mem_d_pkg::*;

  logic [31:0]      mem_d_addr_o;
  logic [31:0]      mem_d_data_wr_o;
  logic             mem_d_rd_o;
  logic [3:0]       mem_d_wr_o;
  logic             mem_d_cacheable_o;
  logic [TAG_W-1:0] mem_d_req_tag_o;
  logic             mem_d_invalidate_o;
  logic             mem_d_writeback_o;
  logic             mem_d_flush_o;
  logic [31:0]      mem_d_data_rd_i;
  logic             mem_d_accept_i;
  logic             mem_d_ack_i;
  logic             mem_d_error_i;
  logic [TAG_W-1:0] mem_d_resp_tag_i;

  modport master (
    output mem_d_addr_o, mem_d_data_wr_o, mem_d_rd_o, mem_d_wr_o,
           mem_d_cacheable_o, mem_d_req_tag_o, mem_d_invalidate_o,
           mem_d_writeback_o, mem_d_flush_o,
    input  mem_d_data_rd_i, mem_d_accept_i, mem_d_ack_i, mem_d_error_i,
           mem_d_resp_tag_i
  );

  modport slave (
    input  mem_d_addr_o, mem_d_data_wr_o, mem_d_rd_o, mem_d_wr_o,
           mem_d_cacheable_o, mem_d_req_tag_o, mem_d_invalidate_o,
           mem_d_writeback_o, mem_d_flush_o,
    output mem_d_data_rd_i, mem_d_accept_i, mem_d_ack_i, mem_d_error_i,
           mem_d_resp_tag_i
  );

endinterface

// File: rtl/mem_d_copy_engine.sv
// Word-copy initiator on the mem_d bus: one outstanding request, ascending read/write pairs.
// Optional fill mode (write a constant, no reads) enabled by defining MEM_D_COPY_FILL_EN.
module mem_d_copy_engine
  import mem_d_pkg::*;
#(
  parameter int unsigned      LEN_W    = 16,
  parameter logic [TAG_W-1:0] TAG_BASE = 11'h400
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [31:0]          src_addr_i,
  input  logic [31:0]          dst_addr_i,
  input  logic [LEN_W-1:0]     len_i,
  input  logic                 fill_i,
  input  logic [31:0]          fill_data_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  mem_d_copy_engine_if.master  mem_d
);

  state_e           state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [31:0]      data_q, data_d;
  logic             done_q, done_d;
  logic             error_q, error_d;

  logic             fill_mode;
  logic [31:0]      wr_word;

`ifdef MEM_D_COPY_FILL_EN
  logic             fill_q, fill_d;
  logic [31:0]      fill_data_q, fill_data_d;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_q      <= 1'b0;
      fill_data_q <= '0;
    end else begin
      fill_q      <= fill_d;
      fill_data_q <= fill_data_d;
    end
  end

  always_comb begin
    fill_d      = fill_q;
    fill_data_d = fill_data_q;
    if (state_q == ST_IDLE && start_i) begin
      fill_d      = fill_i;
      fill_data_d = fill_data_i;
    end
  end

  assign fill_mode = fill_q;
  assign wr_word   = fill_q ? fill_data_q : data_q;
`else
  logic unused_fill;
  assign unused_fill = ^{fill_i, fill_data_i};
  assign fill_mode   = 1'b0;
  assign wr_word     = data_q;
`endif

  logic             unused_align;
  logic [31:0]      word_off;
  logic [TAG_W-1:0] issued_tag;
  logic             resp_bad;
  logic             last_word;

  assign unused_align = ^{src_addr_i[1:0], dst_addr_i[1:0]};
  assign word_off     = 32'(idx_q) << 2;
  // Tag carries the low 10 bits of the word index; zero-extended when LEN_W < 10.
  assign issued_tag   = TAG_BASE | TAG_W'(10'(idx_q));
  assign resp_bad     = mem_d.mem_d_error_i || (mem_d.mem_d_resp_tag_i != issued_tag);
  assign last_word    = (idx_q + LEN_W'(1)) == len_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    idx_d   = idx_q;
    data_d  = data_q;
    done_d  = 1'b0;
    error_d = error_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          src_d   = {src_addr_i[31:2], 2'b00};
          dst_d   = {dst_addr_i[31:2], 2'b00};
          len_d   = len_i;
          idx_d   = '0;
          error_d = 1'b0;
          if (len_i == '0) begin
            done_d = 1'b1;
          end else begin
`ifdef MEM_D_COPY_FILL_EN
            state_d = fill_i ? ST_WR_REQ : ST_RD_REQ;
`else
            state_d = ST_RD_REQ;
`endif
          end
        end
      end

      ST_RD_REQ: begin
        if (mem_d.mem_d_accept_i) state_d = ST_RD_WAIT;
      end

      ST_RD_WAIT: begin
        if (mem_d.mem_d_ack_i) begin
          if (resp_bad) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else begin
            data_d  = mem_d.mem_d_data_rd_i;
            state_d = ST_WR_REQ;
          end
        end
      end

      ST_WR_REQ: begin
        if (mem_d.mem_d_accept_i) state_d = ST_WR_WAIT;
      end

      ST_WR_WAIT: begin
        if (mem_d.mem_d_ack_i) begin
          if (resp_bad) begin
            error_d = 1'b1;
            state_d = ST_IDLE;
          end else if (last_word) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            idx_d   = idx_q + LEN_W'(1);
            state_d = fill_mode ? ST_WR_REQ : ST_RD_REQ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_d.mem_d_addr_o    = '0;
    mem_d.mem_d_data_wr_o = '0;
    mem_d.mem_d_rd_o      = 1'b0;
    mem_d.mem_d_wr_o      = WR_NONE;
    mem_d.mem_d_req_tag_o = '0;
    if (state_q == ST_RD_REQ) begin
      mem_d.mem_d_addr_o    = src_q + word_off;
      mem_d.mem_d_rd_o      = 1'b1;
      mem_d.mem_d_req_tag_o = issued_tag;
    end else if (state_q == ST_WR_REQ) begin
      mem_d.mem_d_addr_o    = dst_q + word_off;
      mem_d.mem_d_data_wr_o = wr_word;
      mem_d.mem_d_wr_o      = WR_ALL;
      mem_d.mem_d_req_tag_o = issued_tag;
    end
  end

  assign mem_d.mem_d_cacheable_o  = 1'b1;
  assign mem_d.mem_d_invalidate_o = 1'b0;
  assign mem_d.mem_d_writeback_o  = 1'b0;
  assign mem_d.mem_d_flush_o      = 1'b0;

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;
  assign error_o = error_q;

endmodule

// File: tb/tb_mem_d_copy_engine.sv
// Directed bench for mem_d_copy_engine with a single-outstanding memory responder.
module tb_mem_d_copy_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        fill;
  logic [31:0] fill_data;
  logic        busy, done, error;

  logic        acc, ack, merr;
  logic [10:0] rtag;
  logic [31:0] rdata;

  mem_d_copy_engine_if ifc ();

  assign ifc.mem_d_accept_i   = acc;
  assign ifc.mem_d_ack_i      = ack;
  assign ifc.mem_d_error_i    = merr;
  assign ifc.mem_d_resp_tag_i = rtag;
  assign ifc.mem_d_data_rd_i  = rdata;

  mem_d_copy_engine #(.LEN_W(16), .TAG_BASE(11'h400)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .src_addr_i  (src),
    .dst_addr_i  (dst),
    .len_i       (len),
    .fill_i      (fill),
    .fill_data_i (fill_data),
    .busy_o      (busy),
    .done_o      (done),
    .error_o     (error),
    .mem_d       (ifc.slave)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  logic [31:0] mem [0:1023];
  int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, alt_err = 0;
  int          last_op = 0;
  int          stall = 0;
  int          err_idx = -1, bad_idx = -1;
  logic        pend = 1'b0, pend_rd;
  logic [10:0] pend_tag;
  logic [31:0] pend_addr;

  // Responder: evaluates on the falling edge, acks one cycle after accept.
  initial begin
    acc = 0; ack = 0; merr = 0; rtag = '0; rdata = '0;
    forever begin
      @(negedge clk);
      ack = 0; merr = 0; rtag = '0; rdata = '0; acc = 0;
      if (rst) pend = 0;
      if (pend) begin
        ack   = 1;
        rtag  = (int'(pend_tag[9:0]) == bad_idx) ? 11'h001 : pend_tag;
        merr  = (int'(pend_tag[9:0]) == err_idx);
        rdata = pend_rd ? mem[pend_addr[11:2]] : 32'h0;
        pend  = 0;
      end
      if (done) done_cnt++;
      if (!rst && (ifc.mem_d_rd_o || ifc.mem_d_wr_o != 4'h0)) begin
        if (stall > 0) begin
          stall--;
          check("bp_addr", ifc.mem_d_addr_o, 32'h100);
          check("bp_tag", 32'(ifc.mem_d_req_tag_o), 32'h400);
          check("bp_rd", 32'(ifc.mem_d_rd_o), 32'h1);
        end else begin
          acc       = 1;
          pend      = 1;
          pend_rd   = ifc.mem_d_rd_o;
          pend_tag  = ifc.mem_d_req_tag_o;
          pend_addr = ifc.mem_d_addr_o;
          if (ifc.mem_d_rd_o) begin
            rd_cnt++;
            if (last_op == 1) alt_err++;
            last_op = 1;
          end else begin
            wr_cnt++;
            if (last_op != 1) alt_err++;
            last_op = 2;
            mem[ifc.mem_d_addr_o[11:2]] = ifc.mem_d_data_wr_o;
          end
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n,
                      input logic f, input logic [31:0] fd);
    src = s; dst = d; len = n; fill = f; fill_data = fd; start = 1;
    step();
    start = 0;
  endtask

  task automatic wait_end(input int max);
    bit seen = 0;
    for (int i = 0; i < max; i++) begin
      if (done || error) begin
        seen = 1;
        break;
      end
      step();
    end
    if (!seen) check("timeout", 32'h0, 32'h1);
  endtask

  int rd0, wr0, dn0;

  initial begin
    rst = 1; start = 0; src = '0; dst = '0; len = '0; fill = 0; fill_data = '0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2]     = 32'h11111111;
    mem[(32'h100 >> 2)+1] = 32'h22222222;
    mem[(32'h100 >> 2)+2] = 32'h33333333;
    mem[(32'h100 >> 2)+3] = 32'h44444444;
    for (int i = 0; i < 5; i++) mem[(32'h300 >> 2) + i] = 32'hA0000000 + 32'(i);
    step(); step();
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_error", 32'(error), 0);
    check("rst_addr", ifc.mem_d_addr_o, 0);
    check("rst_rd", 32'(ifc.mem_d_rd_o), 0);
    check("rst_wr", 32'(ifc.mem_d_wr_o), 0);
    check("rst_tag", 32'(ifc.mem_d_req_tag_o), 0);
    check("rst_cache", 32'(ifc.mem_d_cacheable_o), 1);
    check("rst_tied0", 32'({ifc.mem_d_invalidate_o, ifc.mem_d_writeback_o, ifc.mem_d_flush_o}), 0);
    rst = 0;
    step();

    // Basic 4-word copy
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt; last_op = 0; alt_err = 0;
    kick(32'h100, 32'h800, 16'd4, 0, 32'h0);
    check("cp_busy", 32'(busy), 1);
    wait_end(200);
    check("cp_done", 32'(done), 1);
    check("cp_rds", 32'(rd_cnt - rd0), 4);
    check("cp_wrs", 32'(wr_cnt - wr0), 4);
    check("cp_alt", 32'(alt_err), 0);
    check("cp_m0", mem[32'h800 >> 2], 32'h11111111);
    check("cp_m1", mem[(32'h800 >> 2)+1], 32'h22222222);
    check("cp_m2", mem[(32'h800 >> 2)+2], 32'h33333333);
    check("cp_m3", mem[(32'h800 >> 2)+3], 32'h44444444);
    step();
    check("cp_busy_after", 32'(busy), 0);
    check("cp_done_once", 32'(done_cnt - dn0), 1);
    check("cp_done_low", 32'(done), 0);

    // Backpressure on the first read
    rd0 = rd_cnt; stall = 7;
    kick(32'h100, 32'h900, 16'd1, 0, 32'h0);
    wait_end(200);
    check("bp_reads", 32'(rd_cnt - rd0), 1);
    check("bp_stall_used", 32'(stall), 0);
    check("bp_data", mem[32'h900 >> 2], 32'h11111111);
    step();

    // Zero length
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    kick(32'h100, 32'h800, 16'd0, 0, 32'h0);
    check("z_done", 32'(done), 1);
    check("z_busy", 32'(busy), 0);
    step();
    check("z_done_low", 32'(done), 0);
    check("z_busy2", 32'(busy), 0);
    check("z_traffic", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 0);
    check("z_done_once", 32'(done_cnt - dn0), 1);

    // Error on read ack of word 2
    wr0 = wr_cnt; dn0 = done_cnt; err_idx = 2;
    kick(32'h300, 32'hA00, 16'd5, 0, 32'h0);
    wait_end(300);
    check("e_flag", 32'(error), 1);
    step(); step();
    check("e_sticky", 32'(error), 1);
    check("e_busy", 32'(busy), 0);
    check("e_nodone", 32'(done_cnt - dn0), 0);
    check("e_wrs", 32'(wr_cnt - wr0), 2);
    check("e_m0", mem[32'hA00 >> 2], 32'hA0000000);
    check("e_m1", mem[(32'hA00 >> 2)+1], 32'hA0000001);
    check("e_m2", mem[(32'hA00 >> 2)+2], 32'h0);
    err_idx = -1;
    kick(32'h100, 32'hA80, 16'd1, 0, 32'h0);
    check("e_clear", 32'(error), 0);
    wait_end(200);
    step();

    // Tag mismatch on the first ack
    wr0 = wr_cnt; dn0 = done_cnt; bad_idx = 0;
    kick(32'h100, 32'hB00, 16'd2, 0, 32'h0);
    wait_end(200);
    check("t_flag", 32'(error), 1);
    check("t_wrs", 32'(wr_cnt - wr0), 0);
    check("t_nodone", 32'(done_cnt - dn0), 0);
    bad_idx = -1;
    step();

    // Asynchronous reset while in WR_WAIT
    wr0 = wr_cnt; dn0 = done_cnt;
    kick(32'h100, 32'hC00, 16'd3, 0, 32'h0);
    for (int i = 0; i < 100 && wr_cnt == wr0; i++) step();
    check("r_wr_seen", 32'(wr_cnt - wr0), 1);
    step();
    rst = 1;
    #1;
    check("r_busy", 32'(busy), 0);
    check("r_rd", 32'(ifc.mem_d_rd_o), 0);
    check("r_wr", 32'(ifc.mem_d_wr_o), 0);
    check("r_addr", ifc.mem_d_addr_o, 0);
    check("r_done", 32'(done), 0);
    check("r_error", 32'(error), 0);
    check("r_cache", 32'(ifc.mem_d_cacheable_o), 1);
    step(); step();
    rst = 0;
    rd0 = rd_cnt; wr0 = wr_cnt;
    step(); step(); step();
    check("r_idle", 32'(busy), 0);
    check("r_quiet", 32'((rd_cnt - rd0) + (wr_cnt - wr0)), 0);
    check("r_nodone", 32'(done_cnt - dn0), 0);

`ifdef MEM_D_COPY_FILL_EN
    // Fill mode: writes only
    rd0 = rd_cnt; wr0 = wr_cnt; dn0 = done_cnt;
    kick(32'h100, 32'h200, 16'd3, 1, 32'hDEADBEEF);
    wait_end(200);
    step();
    check("f_rds", 32'(rd_cnt - rd0), 0);
    check("f_wrs", 32'(wr_cnt - wr0), 3);
    check("f_done", 32'(done_cnt - dn0), 1);
    check("f_m0", mem[32'h200 >> 2], 32'hDEADBEEF);
    check("f_m1", mem[(32'h200 >> 2)+1], 32'hDEADBEEF);
    check("f_m2", mem[(32'h200 >> 2)+2], 32'hDEADBEEF);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_d_copy_engine.md
Name: mem_d_copy_engine

Overview:
- Word-copy initiator that drives the data-side memory request interface (mem_d_*) as a bus master.
- Acts as the initiator counterpart to tcm_mem's data port.
- Lets a bench or SoC move blocks of words inside TCM without the core, e.g. preloading or relocating test images.
- Sits beside riscv_core on a mem_d port of tcm_mem; no arbitration is included.

Parameters:
- LEN_W, 16: width of the word-count register; max transfer is 2^LEN_W-1 words.
- TAG_BASE, 11'h400: constant OR-ed into every mem_d_req_tag_o so responses are distinguishable from core traffic.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  single-cycle start pulse; sampled only in IDLE.
- src_addr_i  in  32  source byte address; bits [1:0] forced to 0.
- dst_addr_i  in  32  destination byte address; bits [1:0] forced to 0.
- len_i  in  LEN_W  number of 32-bit words to copy.
- fill_i  in  1  fill mode select (see Optional Feature).
- fill_data_i  in  32  fill pattern.
- busy_o  out  1  high from the cycle after accepted start until done/error.
- done_o  out  1  one-cycle pulse on successful completion.
- error_o  out  1  sticky error flag; cleared by the next accepted start_i.
- mem_d_addr_o  out  32  request address.
- mem_d_data_wr_o  out  32  write data.
- mem_d_rd_o  out  1  read request.
- mem_d_wr_o  out  4  byte write strobes; always 4'hF or 4'h0.
- mem_d_cacheable_o  out  1  tied 1.
- mem_d_req_tag_o  out  11  TAG_BASE | {word index [9:0]}.
- mem_d_invalidate_o, mem_d_writeback_o, mem_d_flush_o  out  1 each  tied 0.
- mem_d_data_rd_i  in  32  read response data.
- mem_d_accept_i  in  1  request accepted this cycle.
- mem_d_ack_i  in  1  response valid.
- mem_d_error_i  in  1  response error; qualified by ack.
- mem_d_resp_tag_i  in  11  response tag.

Behaviour:
- Reset: all outputs 0 except mem_d_cacheable_o=1. FSM returns to IDLE; counters, addresses and the data holding register clear. Reset asserted mid-transfer abandons it silently, with no done_o or error_o.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- IDLE + start_i:
  - Latch src, dst, len; clear error_o; clear word index.
  - len==0: done_o pulses the next cycle, busy_o stays 0, no bus traffic.
  - Otherwise go to RD_REQ.
- RD_REQ: mem_d_rd_o=1, addr=src+4*idx. Hold addr, tag and rd stable until mem_d_accept_i=1, then go to RD_WAIT. rd drops the cycle after accept.
- RD_WAIT: on mem_d_ack_i, capture mem_d_data_rd_i and go to WR_REQ.
- WR_REQ: mem_d_wr_o=4'hF, addr=dst+4*idx, data=captured word. Hold until accept, then go to WR_WAIT.
- WR_WAIT: on ack, idx increments.
  - idx+1==len: go to IDLE with done_o pulse.
  - Otherwise go to RD_REQ.
- Exactly one request is outstanding at any time. Ack is legal no earlier than the cycle after accept. An ack in a REQ state or in IDLE is ignored.
- Error: an ack with mem_d_error_i=1, or with mem_d_resp_tag_i != the issued tag, sets error_o. The engine then returns to IDLE with no done_o; remaining words are skipped.
- Address arithmetic is 32-bit and wraps modulo 2^32 silently.
- start_i while busy is ignored.
- Overlapping src/dst regions are not detected; copy order is ascending.

Optional Feature:
- Macro MEM_D_COPY_FILL_EN.
- Defined: when fill_i=1 at start, the read phase is skipped. The flow is IDLE->WR_REQ directly, writing fill_data_i to every word, with no mem_d_rd_o ever asserted.
- Undefined: fill_i and fill_data_i are ignored and every transfer is a copy.
- Port list is identical in both builds.

Decomposition:
- Shared package mem_d_pkg holds:
  - FSM state enum.
  - Tag width constant (11).
  - Strobe constants WR_ALL=4'hF, WR_NONE=4'h0.
- No sub-module; single flat module.

Test Plan:
- Copy: src=0x100, dst=0x800, len=4, TCM preloaded with 0x11111111..0x44444444 -> exactly 4 reads and 4 writes in strict rd/wr alternation; 0x800..0x80C match; done_o pulses once; busy_o low next cycle.
- Backpressure: mem_d_accept_i held 0 for 7 cycles on the first read -> mem_d_addr_o=0x100, mem_d_req_tag_o=0x400 and rd=1 stable all 7 cycles; single read issued.
- Zero length: len=0 -> done_o one cycle after start; no mem_d_rd_o/mem_d_wr_o activity; busy_o stays 0.
- Error: inject mem_d_error_i on the ack of word 2 of len=5 -> error_o=1; no done_o; only words 0-1 written; a new start_i clears error_o.
- Tag mismatch and reset: an ack with resp_tag 0x001 -> error_o=1. Separately, rst_i asserted in WR_WAIT -> all outputs 0 immediately (asynchronous), FSM in IDLE, no done_o.
- Fill (MEM_D_COPY_FILL_EN defined): fill_i=1, fill_data_i=0xDEADBEEF, dst=0x200, len=3 -> three writes, zero reads, done_o once.
